// File: rtl/accum_store_if.sv
// rtl/accum_store_if.sv - dump stream interface for accum_store
//
// Purpose: carries the 512-bit dump stream from accum_store to the host.
// Signals:
//   tvalid - beat valid (master -> slave)
//   tready - beat accepted (slave -> master)
//   tdata  - eight 64-bit entries, entry 8k+j in tdata[64j+63:64j]
//   tlast  - final beat of a dump
interface accum_store_if;
    logic         tvalid;
    logic         tready;
    logic [511:0] tdata;
    logic         tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/accum_store.sv
// rtl/accum_store.sv - banked 64-bit count store with clear and stream dump
//
// Purpose: holds DEPTH 64-bit entries in eight banks (entry a in bank a[2:0],
// row a/8), accepts one write per cycle in every state, zeroes all rows on
// kick_clear and streams the first N entries eight per beat on kick_dump.
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   accum_addr/din/we  - entry write port (out-of-range writes are dropped)
//   kick_clear         - pulse: zero all entries and both counters
//   kick_dump          - pulse: stream min(num_entries, DEPTH) entries
//   num_entries        - dump length, sampled with kick_dump
//   busy               - high whenever not idle
//   write_count        - saturating count of accepted writes
//   drop_count         - saturating count of out-of-range writes
//   m_axis             - dump stream (master side)
module accum_store #(
    parameter int DEPTH = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         accum_addr,
    input  logic [63:0]         accum_din,
    input  logic                accum_we,
    input  logic                kick_clear,
    input  logic                kick_dump,
    input  logic [31:0]         num_entries,
    output logic                busy,
    output logic [31:0]         write_count,
    output logic [31:0]         drop_count,
    accum_store_if.master       m_axis
);
    localparam int ROWS = DEPTH / 8;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, DUMP_RD, DUMP_OUT} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [RW-1:0]   r_clr_row;
    logic [RW:0]     r_rd_beat;
    logic [RW:0]     r_beats;
    logic [RW+3:0]   r_num;
    logic [31:0]     r_write_count;
    logic [31:0]     r_drop_count;
    logic            r_out_valid;
    logic [511:0]    r_out_data;
    logic            r_out_last;
    logic            r_skd_valid;
    logic [511:0]    r_skd_data;
    logic            r_skd_last;

    logic            w_in_range;
    logic            w_wr_ok;
    logic            w_wr_drop;
    logic [2:0]      w_wr_bank;
    logic [RW-1:0]   w_wr_row;
    logic [RW-1:0]   w_rd_row;
    logic [RW+3:0]   w_n_clip;
    logic [RW:0]     w_beats;
    logic            w_issue;
    logic            w_clr_en;
    logic            w_pop;
    logic            w_kick_clr;
    logic            w_kick_dmp;
    logic [63:0]     w_lane [8];
    logic [511:0]    w_rd_data;
    logic            w_rd_last;

    assign w_in_range = accum_addr < 32'(DEPTH);
    assign w_wr_ok    = accum_we && w_in_range;
    assign w_wr_drop  = accum_we && !w_in_range;
    assign w_wr_bank  = accum_addr[2:0];
    assign w_wr_row   = accum_addr[RW+2:3];
    assign w_rd_row   = r_rd_beat[RW-1:0];

    assign w_n_clip   = (num_entries > 32'(DEPTH)) ? (RW+4)'(DEPTH) : num_entries[RW+3:0];
    assign w_beats    = w_n_clip[RW+3:3] + {{RW{1'b0}}, |w_n_clip[2:0]};

    assign w_kick_clr = (r_state == IDLE) && kick_clear;
    assign w_kick_dmp = (r_state == IDLE) && !kick_clear && kick_dump;
    assign w_pop      = r_out_valid && m_axis.tready;
    assign w_rd_last  = (r_rd_beat == r_beats - 1'b1);

    for (genvar b = 0; b < 8; b++) begin : g_bank
        logic [63:0] r_mem [ROWS];
        logic        w_bank_we;
        logic [63:0] w_bank_q;

        assign w_bank_we = w_wr_ok && (w_wr_bank == 3'(b));

        // A write landing on the row being cleared keeps its data.
        always_ff @(posedge clk) begin
            if (w_bank_we)
                r_mem[w_wr_row] <= accum_din;
            if (w_clr_en && !(w_bank_we && (w_wr_row == r_clr_row)))
                r_mem[r_clr_row] <= '0;
        end

        // Same-cycle write to the row being read bypasses to the new value.
        assign w_bank_q = (w_bank_we && (w_wr_row == w_rd_row)) ? accum_din : r_mem[w_rd_row];
        assign w_lane[b] = ({r_rd_beat, 3'(b)} < r_num) ? w_bank_q : '0;
    end

    always_comb begin
        w_rd_data = '0;
        for (int j = 0; j < 8; j++)
            w_rd_data[64*j +: 64] = w_lane[j];
    end

    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        w_clr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (kick_clear)
                    w_state_nx = CLEAR;
                else if (kick_dump)
                    w_state_nx = DUMP_RD;
            end
            CLEAR: begin
                w_clr_en = 1'b1;
                if (r_clr_row == RW'(ROWS - 1))
                    w_state_nx = IDLE;
            end
            DUMP_RD: begin
                if (r_beats == '0) begin
                    w_state_nx = IDLE;
                end else if (!r_skd_valid) begin
                    // Skid empty means the result of this read always has a slot.
                    w_issue = 1'b1;
                    if (w_rd_last)
                        w_state_nx = DUMP_OUT;
                end
            end
            DUMP_OUT: begin
                if (w_pop && r_out_last)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_clr_row     <= '0;
            r_rd_beat     <= '0;
            r_beats       <= '0;
            r_num         <= '0;
            r_write_count <= '0;
            r_drop_count  <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_skd_valid   <= 1'b0;
            r_skd_data    <= '0;
            r_skd_last    <= 1'b0;
        end else begin
            r_state <= w_state_nx;

            if (w_kick_clr)
                r_clr_row <= '0;
            else if (w_clr_en)
                r_clr_row <= r_clr_row + 1'b1;

            if (w_kick_dmp) begin
                r_num     <= w_n_clip;
                r_beats   <= w_beats;
                r_rd_beat <= '0;
            end else if (w_issue) begin
                r_rd_beat <= r_rd_beat + 1'b1;
            end

            if (w_kick_clr) begin
                r_write_count <= '0;
                r_drop_count  <= '0;
            end else begin
                if (w_wr_ok && (r_write_count != 32'hFFFF_FFFF))
                    r_write_count <= r_write_count + 32'd1;
                if (w_wr_drop && (r_drop_count != 32'hFFFF_FFFF))
                    r_drop_count <= r_drop_count + 32'd1;
            end

            // Output register refills from the skid first, then from the read.
            if (!r_out_valid || w_pop) begin
                if (r_skd_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skd_data;
                    r_out_last  <= r_skd_last;
                    r_skd_valid <= w_issue;
                    if (w_issue) begin
                        r_skd_data <= w_rd_data;
                        r_skd_last <= w_rd_last;
                    end
                end else begin
                    r_out_valid <= w_issue;
                    if (w_issue) begin
                        r_out_data <= w_rd_data;
                        r_out_last <= w_rd_last;
                    end
                end
            end else if (w_issue) begin
                r_skd_valid <= 1'b1;
                r_skd_data  <= w_rd_data;
                r_skd_last  <= w_rd_last;
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign write_count   = r_write_count;
    assign drop_count    = r_drop_count;
    assign m_axis.tvalid = r_out_valid;
    assign m_axis.tdata  = r_out_data;
    assign m_axis.tlast  = r_out_last;
endmodule

// File: tb/tb_accum_store.sv
// tb/tb_accum_store.sv - scoreboard testbench for accum_store
module tb_accum_store;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] accum_addr = '0;
    logic [63:0] accum_din = '0;
    logic        accum_we = 1'b0;
    logic        kick_clear = 1'b0;
    logic        kick_dump = 1'b0;
    logic [31:0] num_entries = '0;
    logic        busy;
    logic [31:0] write_count;
    logic [31:0] drop_count;

    accum_store_if m_axis();

    accum_store #(.DEPTH(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .accum_addr  (accum_addr),
        .accum_din   (accum_din),
        .accum_we    (accum_we),
        .kick_clear  (kick_clear),
        .kick_dump   (kick_dump),
        .num_entries (num_entries),
        .busy        (busy),
        .write_count (write_count),
        .drop_count  (drop_count),
        .m_axis      (m_axis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         last;
        bit           chk;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        e;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           nbeat = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;
    int           kick_cyc = 0;
    logic [511:0] got [64];
    logic [63:0]  mdl [256];
    logic         stall_p = 1'b0;
    logic [511:0] sd;
    logic         sl;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks hold-while-stalled and pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (reset) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                checks++;
                if (!(m_axis.tvalid && m_axis.tdata == sd && m_axis.tlast == sl)) begin
                    errors++;
                    $display("FAIL hold_stable: tvalid=%0b tlast=%0b lane0=%h required tvalid=1 tlast=%0b lane0=%h",
                             m_axis.tvalid, m_axis.tlast, m_axis.tdata[63:0], sl, sd[63:0]);
                end
            end
            if (m_axis.tvalid && m_axis.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got beat lane0=%h tlast=%0b, required no beat", m_axis.tdata[63:0], m_axis.tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis.tlast !== e.last || (e.chk && m_axis.tdata !== e.data)) begin
                        errors++;
                        $display("FAIL beat%0d: tlast=%0b lane0=%h lane7=%h required tlast=%0b lane0=%h lane7=%h",
                                 nbeat, m_axis.tlast, m_axis.tdata[63:0], m_axis.tdata[511:448],
                                 e.last, e.data[63:0], e.data[511:448]);
                    end
                end
                if (nbeat == 0) first_cyc = cyc;
                if (m_axis.tlast) last_cyc = cyc;
                got[nbeat % 64] = m_axis.tdata;
                nbeat++;
            end
            stall_p = m_axis.tvalid && !m_axis.tready;
            sd = m_axis.tdata;
            sl = m_axis.tlast;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [511:0] build(input int k, input int nn);
        logic [511:0] d = '0;
        for (int j = 0; j < 8; j++)
            if (8*k + j < nn) d[64*j +: 64] = mdl[8*k + j];
        return d;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) mdl[i] = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        accum_we = 1'b1; accum_addr = a; accum_din = d;
        @(posedge clk); #1;
        accum_we = 1'b0;
        if (a < 256) mdl[a] = d;
    endtask

    task automatic wait_idle(input string name, output int cnt);
        cnt = 0;
        for (int t = 0; t < 100 && busy; t++) begin
            cnt++;
            @(posedge clk); #1;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic do_clear();
        int cnt;
        kick_clear = 1'b1;
        @(posedge clk); #1;
        kick_clear = 1'b0;
        clear_model();
        wait_idle("clear_done", cnt);
        check("clear_cycles", 64'(cnt), 64'd32);
    endtask

    // mode 0: tready held high; mode 1: tready pattern 1,0,0,1
    task automatic do_dump(input int n, input int mode, input bit chk);
        int   nn;
        int   beats;
        int   cnt;
        logic pat [4];
        beat_t b;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        nn = (n > 256) ? 256 : n;
        beats = (nn + 7) / 8;
        for (int k = 0; k < beats; k++) begin
            b.data = build(k, nn);
            b.last = (k == beats - 1);
            b.chk  = chk;
            exp_q.push_back(b);
        end
        nbeat = 0;
        m_axis.tready = 1'b1;
        kick_dump = 1'b1; num_entries = n; kick_cyc = cyc;
        @(posedge clk); #1;
        kick_dump = 1'b0;
        for (int t = 0; t < 400 && nbeat < beats; t++) begin
            m_axis.tready = (mode == 1) ? pat[t % 4] : 1'b1;
            @(posedge clk); #1;
        end
        m_axis.tready = 1'b1;
        check("dump_beats", 64'(nbeat), 64'(beats));
        if (mode == 0 && beats > 0) begin
            check("first_latency_le3", 64'((first_cyc - kick_cyc) <= 3), 64'd1);
            check("no_bubbles", 64'(last_cyc - first_cyc), 64'(beats - 1));
        end
        wait_idle("dump_done", cnt);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        beat_t b;
        m_axis.tready = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis.tlast), 64'd0);
        check("rst_tdata_zero", 64'(|m_axis.tdata), 64'd0);
        check("rst_write_count", 64'(write_count), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Clear then full dump of zeros.
        do_clear();
        do_dump(256, 0, 1);
        check("full_dump_last_beat_idx", 64'(nbeat), 64'd32);
        check("wc_after_clear", 64'(write_count), 64'd0);

        // Directed writes, one out of range.
        wr(32'd0, 64'd5);
        wr(32'd9, 64'd7);
        wr(32'd255, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(32'd256, 64'd1);
        do_dump(16, 0, 1);
        check("n16_b0_lane0", got[0][63:0], 64'd5);
        check("n16_b1_lane1", got[1][127:64], 64'd7);
        check("write_count", 64'(write_count), 64'd3);
        check("drop_count", 64'(drop_count), 64'd1);

        // Partial final beat with back-pressure.
        do_dump(10, 1, 1);
        check("n10_b1_lane1", got[1][127:64], 64'd7);
        check("n10_b1_hi_zero", 64'(|got[1][511:128]), 64'd0);

        // Both kicks together: clear only; write during row 0 clear survives.
        kick_clear = 1'b1; kick_dump = 1'b1; num_entries = 32'd8;
        @(posedge clk); #1;
        kick_clear = 1'b0; kick_dump = 1'b0;
        clear_model();
        wr(32'd3, 64'h33);
        wait_idle("clear2_done", cnt);
        check("clear2_cycles", 64'(cnt + 1), 64'd32);
        check("wc_write_in_clear", 64'(write_count), 64'd1);
        do_dump(8, 0, 1);
        check("addr3_after_clear", got[0][255:192], 64'h33);

        // N = 0: one busy cycle, no beats.
        kick_dump = 1'b1; num_entries = 32'd0;
        @(posedge clk); #1;
        kick_dump = 1'b0;
        check("n0_busy_high", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("n0_busy_low", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset after beat 2 of a dump.
        for (int k = 0; k < 8; k++) begin
            b.data = build(k, 64);
            b.last = (k == 7);
            b.chk  = 1'b1;
            exp_q.push_back(b);
        end
        nbeat = 0;
        kick_dump = 1'b1; num_entries = 32'd64;
        @(posedge clk); #1;
        kick_dump = 1'b0;
        for (int t = 0; t < 50 && nbeat < 3; t++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_beats", 64'(nbeat), 64'd3);
        reset = 1'b1;
        #1;
        check("reset_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_wc", 64'(write_count), 64'd0);
        do_dump(8, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
